// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - ID/EXE inputs, WB forward port and EXE/MEM outputs of the execute stage
interface exe_stage_if #(
  parameter int XLEN = 32
);
  logic            exe_wreg;
  logic            exe_m2reg;
  logic            exe_wmem;
  logic [4:0]      exe_d;
  logic [2:0]      exe_aluc;
  logic            exe_aluimm;
  logic            exe_shift;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] exe_imm;
  logic [4:0]      exe_rs;
  logic [4:0]      exe_rt;
  logic            exe_beq;
  logic            exe_bne;
  logic            load_depen;
  logic [XLEN-1:0] wdi;
  logic [4:0]      wb_d;
  logic            wb_wreg;
  logic            rsrtequ;
  logic            exe_btaken;
  logic            mem_wreg;
  logic            mem_m2reg;
  logic            mem_wmem;
  logic [4:0]      mem_d;
  logic [XLEN-1:0] mem_alu;
  logic [XLEN-1:0] mem_b;

  modport master (
    output exe_wreg, exe_m2reg, exe_wmem, exe_d, exe_aluc, exe_aluimm, exe_shift,
    output a, b, exe_imm, exe_rs, exe_rt, exe_beq, exe_bne, load_depen,
    output wdi, wb_d, wb_wreg,
    input  rsrtequ, exe_btaken, mem_wreg, mem_m2reg, mem_wmem, mem_d, mem_alu, mem_b
  );

  modport slave (
    input  exe_wreg, exe_m2reg, exe_wmem, exe_d, exe_aluc, exe_aluimm, exe_shift,
    input  a, b, exe_imm, exe_rs, exe_rt, exe_beq, exe_bne, load_depen,
    input  wdi, wb_d, wb_wreg,
    output rsrtequ, exe_btaken, mem_wreg, mem_m2reg, mem_wmem, mem_d, mem_alu, mem_b
  );
endinterface

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: operand forwarding, ALU, branch resolve, EXE/MEM register
module exe_stage #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       clrn,
  exe_stage_if.slave bus
);

  logic            squash_q;
  logic            vld;
  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fb;
  logic [XLEN-1:0] op2;
  logic [4:0]      shamt;
  logic [XLEN-1:0] result;

  // MEM beats WB; loads in MEM are excluded because decode stalls on them
  always_comb begin
    fa = bus.a;
    if (bus.mem_wreg && !bus.mem_m2reg && (bus.mem_d == bus.exe_rs)) begin
      fa = bus.mem_alu;
    end else if (bus.wb_wreg && (bus.wb_d == bus.exe_rs)) begin
      fa = bus.wdi;
    end
  end

  always_comb begin
    fb = bus.b;
    if (bus.mem_wreg && !bus.mem_m2reg && (bus.mem_d == bus.exe_rt)) begin
      fb = bus.mem_alu;
    end else if (bus.wb_wreg && (bus.wb_d == bus.exe_rt)) begin
      fb = bus.wdi;
    end
  end

  assign vld   = ~squash_q;
  assign op2   = bus.exe_aluimm ? bus.exe_imm : fb;
  // shifts always move fB; the amount comes from the immediate or, for variable shifts, from fA
  assign shamt = bus.exe_shift ? bus.exe_imm[4:0] : fa[4:0];

  always_comb begin
    result = '0;
    unique case (bus.exe_aluc)
      3'b000: result = fa + op2;
      3'b001: result = fa - op2;
      3'b010: result = fa & op2;
      3'b011: result = fa | op2;
      3'b100: result = fa ^ op2;
      3'b101: result = fb << shamt;
      3'b110: result = fb >> shamt;
      3'b111: result = $unsigned($signed(fb) >>> shamt);
      default: result = '0;
    endcase
  end

  assign bus.rsrtequ    = (fa == fb);
  assign bus.exe_btaken = vld & ((bus.exe_beq & bus.rsrtequ) | (bus.exe_bne & ~bus.rsrtequ));

  always_ff @(posedge clk) begin
    if (!clrn) begin
      squash_q      <= 1'b0;
      bus.mem_wreg  <= 1'b0;
      bus.mem_m2reg <= 1'b0;
      bus.mem_wmem  <= 1'b0;
      bus.mem_d     <= '0;
      bus.mem_alu   <= '0;
      bus.mem_b     <= '0;
    end else begin
      squash_q      <= bus.load_depen | bus.exe_btaken;
      bus.mem_wreg  <= bus.exe_wreg & vld;
      bus.mem_m2reg <= bus.exe_m2reg & vld;
      bus.mem_wmem  <= bus.exe_wmem & vld;
      bus.mem_d     <= bus.exe_d;
      bus.mem_alu   <= result;
      bus.mem_b     <= fb;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed and randomized check of exe_stage against a behavioural model
module tb_exe_stage;

  logic clk = 1'b0;
  logic clrn;

  exe_stage_if #(.XLEN(32)) bus ();

  exe_stage #(.XLEN(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit known = 1'b0;

  // model of what the EXE/MEM register and the kill flag should hold
  logic        m_sq, m_wreg, m_m2reg, m_wmem;
  logic [4:0]  m_d;
  logic [31:0] m_alu, m_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] regv);
    if (m_wreg && !m_m2reg && m_d == src) return m_alu;
    if (bus.wb_wreg && bus.wb_d == src) return bus.wdi;
    return regv;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] v,
                                          input logic [4:0] n);
    case (op)
      3'd0: return x + y;
      3'd1: return x + (~y) + 32'd1;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return v << n;
      3'd6: return v >> n;
      default: return v[31] ? ~((~v) >> n) : (v >> n);
    endcase
  endfunction

  task automatic idle();
    clrn           = 1'b1;
    bus.exe_wreg   = 0; bus.exe_m2reg = 0; bus.exe_wmem = 0; bus.exe_d = 0;
    bus.exe_aluc   = 0; bus.exe_aluimm = 0; bus.exe_shift = 0;
    bus.a          = 0; bus.b = 0; bus.exe_imm = 0; bus.exe_rs = 0; bus.exe_rt = 0;
    bus.exe_beq    = 0; bus.exe_bne = 0; bus.load_depen = 0;
    bus.wdi        = 0; bus.wb_d = 0; bus.wb_wreg = 0;
  endtask

  task automatic step();
    logic [31:0] fa, fb, op2, res;
    logic [4:0]  n;
    logic        eq, bt, rst_s, ld_s, w_s, m_s, s_s;
    logic [4:0]  d_s;
    #2;
    fa  = fwd(bus.exe_rs, bus.a);
    fb  = fwd(bus.exe_rt, bus.b);
    eq  = (fa == fb);
    bt  = known && !m_sq && ((bus.exe_beq && eq) || (bus.exe_bne && !eq));
    if (known) begin
      check("rsrtequ", bus.rsrtequ, eq);
      check("btaken", bus.exe_btaken, bt);
    end
    op2 = bus.exe_aluimm ? bus.exe_imm : fb;
    n   = bus.exe_shift ? bus.exe_imm[4:0] : fa[4:0];
    res = alu_ref(bus.exe_aluc, fa, op2, fb, n);
    rst_s = !clrn; ld_s = bus.load_depen; d_s = bus.exe_d;
    w_s = bus.exe_wreg; m_s = bus.exe_m2reg; s_s = bus.exe_wmem;
    @(posedge clk);
    #1;
    if (rst_s) begin
      m_sq = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_d = 0; m_alu = 0; m_b = 0;
      known = 1'b1;
    end else if (known) begin
      m_wreg  = w_s & !m_sq;
      m_m2reg = m_s & !m_sq;
      m_wmem  = s_s & !m_sq;
      m_sq    = ld_s | bt;
      m_d     = d_s;
      m_alu   = res;
      m_b     = fb;
    end
    if (known) begin
      check("mem_wreg", bus.mem_wreg, m_wreg);
      check("mem_m2reg", bus.mem_m2reg, m_m2reg);
      check("mem_wmem", bus.mem_wmem, m_wmem);
      check("mem_d", bus.mem_d, m_d);
      check("mem_alu", bus.mem_alu, m_alu);
      check("mem_b", bus.mem_b, m_b);
    end
  endtask

  initial begin
    // reset held two cycles with busy, non-branch inputs
    idle();
    clrn = 0; bus.exe_wreg = 1; bus.exe_wmem = 1; bus.exe_m2reg = 1; bus.exe_d = 9;
    bus.a = 32'h55; bus.b = 32'h66; bus.load_depen = 1;
    step(); step();
    check("rst_mem_wreg", bus.mem_wreg, 0);
    check("rst_mem_alu", bus.mem_alu, 0);
    check("rst_btaken", bus.exe_btaken, 0);

    idle(); bus.exe_wreg = 1; bus.exe_d = 1; bus.exe_rs = 1; bus.exe_rt = 2; bus.a = 3; bus.b = 4;
    step();
    check("first_add", bus.mem_alu, 7);
    check("first_wreg", bus.mem_wreg, 1);

    // MEM forwarding, then MEM vs WB on the same register
    idle(); bus.exe_wreg = 1; bus.exe_d = 5; bus.exe_rs = 7; bus.exe_rt = 8; bus.a = 10; bus.b = 5;
    step();
    idle(); bus.exe_aluc = 1; bus.exe_rs = 5; bus.a = 0; bus.b = 3; bus.exe_d = 6; bus.exe_wreg = 1;
    step();
    check("fwd_mem", bus.mem_alu, 12);
    idle(); bus.exe_wreg = 1; bus.exe_d = 5; bus.exe_rs = 7; bus.exe_rt = 8; bus.a = 10; bus.b = 5;
    step();
    idle(); bus.exe_aluc = 1; bus.exe_rs = 5; bus.b = 3; bus.exe_d = 6; bus.exe_wreg = 1;
    bus.wb_wreg = 1; bus.wb_d = 5; bus.wdi = 99;
    step();
    check("fwd_mem_wins", bus.mem_alu, 12);

    // taken beq squashes exactly one slot
    idle(); bus.exe_beq = 1; bus.exe_rs = 7; bus.exe_rt = 7; bus.a = 32'h1234; bus.b = 32'h1234;
    #1;
    check("beq_eq", bus.rsrtequ, 1);
    check("beq_taken", bus.exe_btaken, 1);
    step();
    idle(); bus.exe_wreg = 1; bus.exe_rs = 8; bus.exe_rt = 9;
    step();
    check("beq_squash", bus.mem_wreg, 0);
    step();
    check("beq_after", bus.mem_wreg, 1);
    idle(); bus.exe_bne = 1; bus.exe_rs = 7; bus.exe_rt = 8; bus.a = 32'h1234; bus.b = 32'h1234;
    #1;
    check("bne_not_taken", bus.exe_btaken, 0);
    step();
    idle(); bus.exe_wreg = 1; bus.exe_rs = 8; bus.exe_rt = 9;
    step();
    check("bne_no_squash", bus.mem_wreg, 1);

    // load bubble kills a store and a branch in the next slot
    idle(); bus.load_depen = 1;
    step();
    idle(); bus.exe_wmem = 1; bus.exe_beq = 1; bus.exe_rs = 7; bus.exe_rt = 8; bus.a = 4; bus.b = 4;
    #1;
    check("ld_branch_dead", bus.exe_btaken, 0);
    step();
    check("ld_store_dead", bus.mem_wmem, 0);

    // shifts and wrap-around subtract
    idle(); bus.exe_aluc = 7; bus.exe_shift = 1; bus.exe_rt = 9; bus.b = 32'h8000_0000; bus.exe_imm = 4;
    step();
    check("sra", bus.mem_alu, 32'hF800_0000);
    bus.exe_aluc = 6;
    step();
    check("srl", bus.mem_alu, 32'h0800_0000);
    bus.exe_aluc = 5; bus.exe_imm = 1;
    step();
    check("sll", bus.mem_alu, 0);
    idle(); bus.exe_aluc = 1; bus.exe_rs = 8; bus.exe_rt = 9; bus.a = 0; bus.b = 1;
    step();
    check("sub_wrap", bus.mem_alu, 32'hFFFF_FFFF);

    // reset while the slot is marked for squash
    idle(); bus.load_depen = 1;
    step();
    idle(); bus.exe_wmem = 1; clrn = 0;
    step();
    check("rst_mid_wmem", bus.mem_wmem, 0);
    clrn = 1;
    step();
    check("post_rst_store", bus.mem_wmem, 1);

    for (int i = 0; i < 400; i++) begin
      clrn           = ($urandom_range(0, 39) != 0);
      bus.exe_wreg   = $urandom_range(0, 1);
      bus.exe_m2reg  = ($urandom_range(0, 3) == 0);
      bus.exe_wmem   = $urandom_range(0, 1);
      bus.exe_d      = 5'($urandom_range(0, 3));
      bus.exe_aluc   = 3'($urandom_range(0, 7));
      bus.exe_aluimm = $urandom_range(0, 1);
      bus.exe_shift  = (bus.exe_aluc >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.a          = $urandom;
      bus.b          = ($urandom_range(0, 3) == 0) ? bus.a : $urandom;
      bus.exe_imm    = $urandom;
      bus.exe_rs     = 5'($urandom_range(0, 3));
      bus.exe_rt     = 5'($urandom_range(0, 3));
      bus.exe_beq    = ($urandom_range(0, 3) == 0);
      bus.exe_bne    = ($urandom_range(0, 3) == 0);
      bus.load_depen = ($urandom_range(0, 5) == 0);
      bus.wdi        = $urandom;
      bus.wb_d       = 5'($urandom_range(0, 3));
      bus.wb_wreg    = $urandom_range(0, 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage pipelined CPU: the consumer of the ID/EXE pipeline register driven by the decode stage. Each cycle it forwards operands from the MEM and WB stages, runs the ALU, and resolves conditional branches (`rsrtequ`, `exe_btaken` back to decode/fetch). It latches results into the EXE/MEM pipeline register and squashes the instruction slot that follows a load bubble or a taken branch.

## Interface
- `XLEN`, 32, datapath width (only 32 supported)
- `clk`  in  1  pipeline clock, all state on rising edge
- `clrn`  in  1  synchronous active-low reset
- `exe_wreg`, `exe_m2reg`, `exe_wmem`  in  1 each  ID/EXE control: reg write, load, store
- `exe_d`  in  5  destination register number
- `exe_aluc`  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra
- `exe_aluimm`, `exe_shift`  in  1 each  B-operand = imm; shift uses imm[4:0] as shamt
- `a`, `b`, `exe_imm`  in  32 each  register operands, extended immediate
- `exe_rs`, `exe_rt`  in  5 each  source register numbers
- `exe_beq`, `exe_bne`  in  1 each  conditional branch in EXE
- `load_depen`  in  1  decode reports load-use hazard this cycle
- `wdi`  in  32; `wb_d`  in  5; `wb_wreg`  in  1  WB-stage write port (forward source)
- `rsrtequ`  out  1  forwarded A == forwarded B (combinational)
- `exe_btaken`  out  1  valid conditional branch taken this cycle
- `mem_wreg`, `mem_m2reg`, `mem_wmem`  out  1 each  EXE/MEM control
- `mem_d`  out  5; `mem_alu`  out  32; `mem_b`  out  32  dest, ALU result, store data

## Operation
- Slot valid: `vld = ~squash_q`. `squash_q` is a 1-bit register: next value = `load_depen | exe_btaken`; cleared on reset.
- Forwarding, per operand (A uses `exe_rs`/`a`, B uses `exe_rt`/`b`), priority order:
  - MEM hit: `mem_wreg & ~mem_m2reg & mem_d == src` → `mem_alu`
  - WB hit: `wb_wreg & wb_d == src` → `wdi`
  - else register value. No special case for r0. MEM-stage load results are never forwarded (decode stalls those).
- ALU operand 2 = `exe_aluimm ? exe_imm : fB`. Shifts (`exe_shift=1`) shift fB by `exe_imm[4:0]`; sra sign-fills from bit 31.
- Add/sub modulo 2^32; no overflow trap.
- `rsrtequ = (fA == fB)`, independent of `vld`.
- `exe_btaken = vld & ((exe_beq & rsrtequ) | (exe_bne & ~rsrtequ))`.
- EXE/MEM register each edge: `mem_alu` ← result, `mem_b` ← fB, `mem_d` ← `exe_d`, control bits ← inputs AND `vld`. Squashed slot writes zero control bits; data fields still update.

## Timing
- Reset (`clrn=0` at edge): `squash_q`, `mem_wreg`, `mem_m2reg`, `mem_wmem` = 0; `mem_d` = 0; `mem_alu`, `mem_b` = 0. Reset overrides every other input that cycle.
- `rsrtequ`, `exe_btaken`: combinational, same cycle as instruction in EXE.
- EXE→MEM latency: 1 cycle.
- Squash latency: `load_depen` or `exe_btaken` high in cycle N kills the slot in EXE during N+1 only. A squashed branch cannot assert `exe_btaken`, so no chained squash.
- `load_depen` and `exe_btaken` together: one squash, same as either alone.
- Reset deasserted mid-stream: first post-reset slot is valid (`squash_q`=0).
- MEM and WB hit the same register: MEM wins.

## Test plan
- Reset: hold `clrn=0` 2 cycles with nonzero inputs → all `mem_*` = 0, `exe_btaken`=0; release → first add of a=3,b=4 gives `mem_alu`=7, `mem_wreg`=1 one cycle later.
- Forwarding: cycle N add r5=10+5 (`exe_d`=5); N+1 sub with `exe_rs`=5, stale a=0, b=3 → `mem_alu`=12. Repeat with MEM and WB both targeting r5 (`wdi`=99) → MEM value used.
- Branch: `exe_beq`=1, a=b=0x1234 → `rsrtequ`=1, `exe_btaken`=1; next slot (`exe_wreg`=1) → `mem_wreg`=0; slot after that normal. Same with `exe_bne` → not taken, no squash.
- Load bubble: `load_depen`=1 one cycle → following store (`exe_wmem`=1) yields `mem_wmem`=0; branch in the squashed slot with equal operands → `exe_btaken`=0.
- ALU ops: b=0x80000000, imm=4: sra → 0xF8000000, srl → 0x08000000, sll(imm=1) → 0; a=0,b=1 sub → 0xFFFFFFFF.
- Reset mid-operation: assert `clrn=0` while `squash_q`=1 and a store in EXE → `mem_wmem`=0, `squash_q`=0 after release.
